mem_responder_mc: RTL and testbench

//  Multi-cycle memory responder: the memory side of the CPU load/store/fetch request interface.

---
 rtl/mem_responder_mc_pkg.sv | 16 +
 rtl/mem_responder_mc_array.sv | 31 +++
 rtl/mem_responder_mc.sv | 116 +++++++++++
 tb/tb_mem_responder_mc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_mc_pkg.sv
// Shared definitions for the multi-cycle memory responder: FSM encodings and default widths.
package mem_responder_mc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 16;

  // Latency counter only ever holds LATENCY-2, so this width can never wrap.
  function automatic int unsigned cnt_width(input int unsigned latency);
    return $clog2(latency) + 1;
  endfunction

endpackage

// File: rtl/mem_responder_mc_array.sv
// Single-port word array with synchronous write and registered synchronous read.
module mem_array #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2)-1];
  logic [DATA_W-1:0] rdata_q;

  // Contents deliberately have no reset; only the read register does.
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder_mc.sv
// Memory side of the CPU request interface: one request at a time, access after LATENCY cycles.
module mem_responder_mc
  import mem_responder_mc_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 4,
  parameter string       INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam int unsigned          CNT_W    = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0]     CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic                  accept, go_resp;
  logic                  acc_wr;
  logic [DEPTH_LOG2-1:0] acc_idx, req_idx;
  logic [DATA_W-1:0]     acc_wdata;
  logic                  unused_addr_bits;

  assign req_idx          = req_addr[DEPTH_LOG2:1];
  assign unused_addr_bits = ^{req_addr[ADDR_W-1:DEPTH_LOG2+1], req_addr[0]};

  assign req_ready = (state_q != ST_WAIT);
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE) && !rsp_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    go_resp = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          wr_d    = req_wr;
          idx_d   = req_idx;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
    endcase
  end

  // The access commits on the edge entering RESP; with LATENCY==1 that edge is the
  // accept edge itself, so the live request is used instead of the capture registers.
  assign acc_wr    = (state_q == ST_WAIT) ? wr_q    : req_wr;
  assign acc_idx   = (state_q == ST_WAIT) ? idx_q   : req_idx;
  assign acc_wdata = (state_q == ST_WAIT) ? wdata_q : req_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  mem_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (go_resp & acc_wr),
    .re_i   (go_resp & ~acc_wr),
    .addr_i (acc_idx),
    .wdata_i(acc_wdata),
    .rdata_o(rsp_rdata)
  );

endmodule

// File: tb/tb_mem_responder_mc.sv
// Directed checks of the responder at LATENCY=4 and LATENCY=1, plus a random LATENCY=1 scoreboard.
module tb_mem_responder_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_wr, a_ready, a_rsp, a_busy;
  logic [15:0] a_addr, a_wdata, a_rdata;
  logic        b_valid, b_wr, b_ready, b_rsp, b_busy;
  logic [15:0] b_addr, b_wdata, b_rdata;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] mdl   [0:1023];
  bit          known [0:1023];

  always #5 clk = ~clk;

  mem_responder_mc #(
    .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(4), .INIT_FILE("")
  ) u_l4 (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_wr(a_wr), .req_addr(a_addr),
    .req_wdata(a_wdata), .req_ready(a_ready), .rsp_valid(a_rsp), .rsp_rdata(a_rdata), .busy(a_busy)
  );

  mem_responder_mc #(
    .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(1), .INIT_FILE("")
  ) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_wr(b_wr), .req_addr(b_addr),
    .req_wdata(b_wdata), .req_ready(b_ready), .rsp_valid(b_rsp), .rsp_rdata(b_rdata), .busy(b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_idle();
    a_valid = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  // Issues one request on the LATENCY=4 instance and returns measurements; callers compare.
  task automatic a_xact(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        output int lat, output int acc, output logic [15:0] rdata,
                        output int wait_bad);
    a_valid = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wdata;
    step();
    acc = cyc;
    a_valid = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    lat = 1;
    wait_bad = 0;
    while (!a_rsp && lat < 12) begin
      if (a_ready !== 1'b0 || a_busy !== 1'b1) wait_bad++;
      step();
      lat++;
    end
    rdata = a_rdata;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    step(); step();
    n_vec++; if (a_ready !== 1'b1)  begin n_err++; $display("FAIL rst_a_ready: got %b want 1", a_ready); end
    n_vec++; if (a_rsp !== 1'b0)    begin n_err++; $display("FAIL rst_a_rsp: got %b want 0", a_rsp); end
    n_vec++; if (a_rdata !== 16'h0) begin n_err++; $display("FAIL rst_a_rdata: got %h want 0000", a_rdata); end
    n_vec++; if (a_busy !== 1'b0)   begin n_err++; $display("FAIL rst_a_busy: got %b want 0", a_busy); end
    n_vec++; if (b_ready !== 1'b1)  begin n_err++; $display("FAIL rst_b_ready: got %b want 1", b_ready); end
    n_vec++; if (b_rsp !== 1'b0)    begin n_err++; $display("FAIL rst_b_rsp: got %b want 0", b_rsp); end
    n_vec++; if (b_rdata !== 16'h0) begin n_err++; $display("FAIL rst_b_rdata: got %h want 0000", b_rdata); end
    n_vec++; if (b_busy !== 1'b0)   begin n_err++; $display("FAIL rst_b_busy: got %b want 0", b_busy); end
    rst_n = 1'b1;
    step(); step();
    n_vec++; if (a_ready !== 1'b1 || a_rsp !== 1'b0 || a_busy !== 1'b0)
      begin n_err++; $display("FAIL idle_a: got ready=%b rsp=%b busy=%b want 1/0/0", a_ready, a_rsp, a_busy); end
  endtask

  task automatic test_latency();
    int lat, acc, wb;
    logic [15:0] rd;
    a_xact(1'b1, 16'h0010, 16'h1234, lat, acc, rd, wb);
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL wr_latency: got %0d want 4", lat); end
    n_vec++; if (wb != 0)  begin n_err++; $display("FAIL wr_wait_ready: got %0d bad cycles want 0", wb); end
    step();
    n_vec++; if (a_rsp !== 1'b0 || a_ready !== 1'b1)
      begin n_err++; $display("FAIL resp_to_idle: got rsp=%b ready=%b want 0/1", a_rsp, a_ready); end
    a_xact(1'b0, 16'h0010, 16'h0000, lat, acc, rd, wb);
    n_vec++; if (lat != 4)      begin n_err++; $display("FAIL rd_latency: got %0d want 4", lat); end
    n_vec++; if (wb != 0)       begin n_err++; $display("FAIL rd_wait_ready: got %0d bad cycles want 0", wb); end
    n_vec++; if (rd !== 16'h1234) begin n_err++; $display("FAIL rd_0010: got %h want 1234", rd); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat, acc1, acc2, acc3, wb;
    logic [15:0] rd;
    a_xact(1'b0, 16'h0010, 16'h0000, lat, acc1, rd, wb);
    n_vec++; if (rd !== 16'h1234) begin n_err++; $display("FAIL b2b_rd0: got %h want 1234", rd); end
    a_xact(1'b1, 16'h0020, 16'hBEEF, lat, acc2, rd, wb);
    n_vec++; if (acc2 - acc1 != 4) begin n_err++; $display("FAIL b2b_space1: got %0d want 4", acc2 - acc1); end
    n_vec++; if (lat != 4)         begin n_err++; $display("FAIL b2b_wr_lat: got %0d want 4", lat); end
    a_xact(1'b0, 16'h0020, 16'h0000, lat, acc3, rd, wb);
    n_vec++; if (acc3 - acc2 != 4) begin n_err++; $display("FAIL b2b_space2: got %0d want 4", acc3 - acc2); end
    n_vec++; if (rd !== 16'hBEEF)  begin n_err++; $display("FAIL b2b_raw: got %h want beef", rd); end
    step();
  endtask

  task automatic test_lat1_stream();
    logic [15:0] exp_rd;
    n_vec++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL l1_ready0: got %b want 1", b_ready); end
    b_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_wr    = (i % 2 == 0);
      b_addr  = 16'h0100 + 16'((i / 2) * 2);
      b_wdata = 16'hC000 + 16'(i);
      step();
      n_vec++; if (b_rsp !== 1'b1 || b_ready !== 1'b1)
        begin n_err++; $display("FAIL l1_stream_%0d: got rsp=%b ready=%b want 1/1", i, b_rsp, b_ready); end
      if (!b_wr) begin
        exp_rd = 16'hC000 + 16'(i - 1);
        n_vec++; if (b_rdata !== exp_rd)
          begin n_err++; $display("FAIL l1_rd_%0d: got %h want %h", i, b_rdata, exp_rd); end
      end
    end
    b_valid = 1'b0; b_wr = 1'b0;
    step();
    n_vec++; if (b_rsp !== 1'b0) begin n_err++; $display("FAIL l1_idle: got rsp=%b want 0", b_rsp); end
  endtask

  task automatic test_reset_mid();
    int lat, acc, wb;
    logic [15:0] rd;
    a_xact(1'b1, 16'h0030, 16'h5555, lat, acc, rd, wb);
    step();
    a_valid = 1'b1; a_wr = 1'b1; a_addr = 16'h0030; a_wdata = 16'hAAAA;
    step();
    a_valid = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    step(); step();
    rst_n = 1'b0;
    #1;
    n_vec++; if (a_ready !== 1'b1)  begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", a_ready); end
    n_vec++; if (a_rsp !== 1'b0)    begin n_err++; $display("FAIL mid_rst_rsp: got %b want 0", a_rsp); end
    n_vec++; if (a_busy !== 1'b0)   begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", a_busy); end
    n_vec++; if (a_rdata !== 16'h0) begin n_err++; $display("FAIL mid_rst_rdata: got %h want 0000", a_rdata); end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++; if (a_rsp !== 1'b0) begin n_err++; $display("FAIL mid_rst_ghost_rsp: got %b want 0", a_rsp); end
    end
    a_xact(1'b0, 16'h0030, 16'h0000, lat, acc, rd, wb);
    n_vec++; if (rd !== 16'h5555) begin n_err++; $display("FAIL mid_rst_dropped: got %h want 5555", rd); end
    step();
  endtask

  task automatic test_hold_during_wait();
    int lat, acc, wb, k;
    logic [15:0] rd;
    logic [15:0] alias_addr [0:3];
    alias_addr[0] = 16'h0050; alias_addr[1] = 16'h0051;
    alias_addr[2] = 16'h0850; alias_addr[3] = 16'hF851;
    a_xact(1'b1, 16'h0050, 16'h1111, lat, acc, rd, wb);
    step();
    a_valid = 1'b1; a_wr = 1'b1; a_addr = 16'h0040; a_wdata = 16'h7777;
    step();
    k = 1;
    while (!a_rsp && k < 12) begin
      n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready_%0d: got %b want 0", k, a_ready); end
      a_addr  = alias_addr[k % 4];
      a_wdata = 16'hDEAD ^ 16'(k);
      step();
      k++;
    end
    a_valid = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    n_vec++; if (k != 4) begin n_err++; $display("FAIL hold_latency: got %0d want 4", k); end
    step();
    a_xact(1'b0, 16'h0050, 16'h0000, lat, acc, rd, wb);
    n_vec++; if (rd !== 16'h1111) begin n_err++; $display("FAIL hold_ignored: got %h want 1111", rd); end
    a_xact(1'b0, 16'h0040, 16'h0000, lat, acc, rd, wb);
    n_vec++; if (rd !== 16'h7777) begin n_err++; $display("FAIL hold_wr_0040: got %h want 7777", rd); end
    a_xact(1'b0, 16'h0031, 16'h0000, lat, acc, rd, wb);
    n_vec++; if (rd !== 16'h5555) begin n_err++; $display("FAIL alias_0031: got %h want 5555", rd); end
    a_xact(1'b0, 16'hF850, 16'h0000, lat, acc, rd, wb);
    n_vec++; if (rd !== 16'h1111) begin n_err++; $display("FAIL alias_f850: got %h want 1111", rd); end
    step();
  endtask

  task automatic test_random();
    logic [4:0] hi, idx5;
    logic       lsb;
    logic [9:0] idx;
    for (int i = 0; i < 1024; i++) known[i] = 1'b0;
    b_valid = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      hi   = 5'($urandom_range(0, 31));
      idx5 = 5'($urandom_range(0, 31));
      lsb  = 1'($urandom_range(0, 1));
      b_wr    = 1'($urandom_range(0, 1));
      b_addr  = {hi, 5'b00000, idx5, lsb};
      b_wdata = 16'($urandom);
      idx     = {5'b00000, idx5};
      step();
      n_vec++; if (b_rsp !== 1'b1) begin n_err++; $display("FAIL rnd_rsp_%0d: got %b want 1", n, b_rsp); end
      if (b_wr) begin
        mdl[idx]   = b_wdata;
        known[idx] = 1'b1;
      end else if (known[idx]) begin
        n_vec++; if (b_rdata !== mdl[idx])
          begin n_err++; $display("FAIL rnd_rd_%0d: addr %h got %h want %h", n, b_addr, b_rdata, mdl[idx]); end
      end
    end
    b_valid = 1'b0; b_wr = 1'b0;
    step();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_lat1_stream();
    test_reset_mid();
    test_hold_during_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
